// File: rtl/exwb_ctrl_pkg.sv
// Shared types for the EX/WB hazard and redirect controller.
// Optional perf counters in the top are enabled by EXWB_CTRL_PERF_EN.
package exwb_ctrl_pkg;

    localparam int unsigned RW_DEF = 6;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_ALU = 2'd1,
        PC_MEM = 2'd2
    } pc_src_e;

    // jumpmem takes priority over jump and branches when choosing the target.
    function automatic pc_src_e sel_target(input logic jumpmem);
        return jumpmem ? PC_MEM : PC_ALU;
    endfunction

endpackage

// File: rtl/exwb_hazard_cmp.sv
// Read-after-write hazard detector: IF/ID sources against ID/EX and EX/WB destinations.
// No forwarding exists, so any match against a pending write is a hazard.
module exwb_hazard_cmp #(
    parameter int unsigned RW = 6
) (
    input  logic          i_id_rs_used,
    input  logic          i_id_rt_used,
    input  logic [RW-1:0] i_id_rs,
    input  logic [RW-1:0] i_id_rt,
    input  logic          i_ex_regwrt,
    input  logic [RW-1:0] i_ex_rd,
    input  logic          i_wb_regwrt,
    input  logic [RW-1:0] i_wb_rd,
    output logic          o_hazard
);

    logic w_rs_ex;
    logic w_rs_wb;
    logic w_rt_ex;
    logic w_rt_wb;

    // Register 0 is an ordinary register here, so it is compared like any other.
    assign w_rs_ex = i_id_rs_used & i_ex_regwrt & (i_id_rs == i_ex_rd);
    assign w_rs_wb = i_id_rs_used & i_wb_regwrt & (i_id_rs == i_wb_rd);
    assign w_rt_ex = i_id_rt_used & i_ex_regwrt & (i_id_rt == i_ex_rd);
    assign w_rt_wb = i_id_rt_used & i_wb_regwrt & (i_id_rt == i_wb_rd);

    assign o_hazard = w_rs_ex | w_rs_wb | w_rt_ex | w_rt_wb;

endmodule

// File: rtl/exwb_hazard_ctrl.sv
// Pipeline sequencer: resolves EX/WB control transfer, redirects the PC, flushes younger
// stages and stalls IF/ID on RAW hazards. Define EXWB_CTRL_PERF_EN to add perf counters.
module exwb_hazard_ctrl
    import exwb_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned RW        = RW_DEF
`ifdef EXWB_CTRL_PERF_EN
    ,
    parameter int unsigned PERF_W    = 32
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_n,
    input  logic          wb_z,
    input  logic          wb_brn,
    input  logic          wb_brz,
    input  logic          wb_jump,
    input  logic          wb_jumpmem,
    input  logic          wb_regwrt,
    input  logic [RW-1:0] wb_rd,
    input  logic          ex_regwrt,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    output logic          pc_load,
    output logic [1:0]    pc_src,
    output logic          flush_o,
    output logic          stall_o
`ifdef EXWB_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_taken,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    localparam int unsigned CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pc_load;
    logic             w_pc_load_nxt;
    pc_src_e          r_pc_src;
    pc_src_e          w_pc_src_nxt;
    logic             r_flush;
    logic             w_flush_nxt;

    logic w_taken;
    logic w_hazard;
    logic w_redirect;
    logic w_stall;

    assign w_taken = wb_jump | wb_jumpmem | (wb_brz & wb_z) | (wb_brn & wb_n);

    exwb_hazard_cmp #(
        .RW (RW)
    ) u_hazard_cmp (
        .i_id_rs_used (id_rs_used),
        .i_id_rt_used (id_rt_used),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_ex_regwrt  (ex_regwrt),
        .i_ex_rd      (ex_rd),
        .i_wb_regwrt  (wb_regwrt),
        .i_wb_rd      (wb_rd),
        .o_hazard     (w_hazard)
    );

    assign w_redirect = (r_state == RUN) & w_taken;
    // A redirect kills the stalled instruction anyway; rst_n keeps stall low during reset.
    assign w_stall    = rst_n & (r_state == RUN) & ~w_taken & w_hazard;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_load_nxt = 1'b0;
        w_pc_src_nxt  = PC_INC;
        w_flush_nxt   = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_taken) begin
                    w_state_nxt   = FLUSH;
                    w_cnt_nxt     = CNT_INIT;
                    w_pc_load_nxt = 1'b1;
                    w_pc_src_nxt  = sel_target(wb_jumpmem);
                    w_flush_nxt   = 1'b1;
                end
            end
            FLUSH: begin
                // Branch flags seen here belong to flushed instructions and are ignored.
                if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                    w_flush_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_pc_load <= 1'b0;
            r_pc_src  <= PC_INC;
            r_flush   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pc_load <= w_pc_load_nxt;
            r_pc_src  <= w_pc_src_nxt;
            r_flush   <= w_flush_nxt;
        end
    end

    assign pc_load = r_pc_load;
    assign pc_src  = r_pc_src;
    assign flush_o = r_flush;
    assign stall_o = w_stall;

`ifdef EXWB_CTRL_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] r_perf_taken;
    logic [PERF_W-1:0] r_perf_stall;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_taken <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_redirect && (r_perf_taken != '1)) begin
                r_perf_taken <= r_perf_taken + PERF_ONE;
            end
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + PERF_ONE;
            end
        end
    end

    assign perf_taken = r_perf_taken;
    assign perf_stall = r_perf_stall;
`else
    logic w_unused_redirect;
    assign w_unused_redirect = w_redirect;
`endif

endmodule
